apb_slave_regfile: RTL and testbench



---
 rtl/apb_slv_pkg.sv | 24 ++
 rtl/apb_slave_regfile_if.sv | 26 ++
 rtl/apb_slv_decode.sv | 23 ++
 rtl/apb_slave_regfile.sv | 122 ++++++++++++
 tb/tb_apb_slave_regfile.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and address-check helper for APB completers.
// Holds the FSM state type, default sizing and the common error rule.
package apb_slv_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    localparam int          NREGS_DEFAULT    = 8;
    localparam int          IDXW             = $clog2(NREGS_DEFAULT);
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    // Word 0 is read-only and the last word only accepts privileged writes.
    function automatic logic addr_err(input logic [63:0] paddr,
                                      input logic        pwrite,
                                      input logic        pprot_priv,
                                      input int          nregs);
        logic [63:0] word;
        word = paddr >> 2;
        return (paddr[1:0] != 2'b00)
            || (paddr >= 64'(nregs) * 64'd4)
            || (pwrite && (word == '0))
            || (pwrite && !pprot_priv && (word == 64'(nregs - 1)));
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between the bridge-side requester and a completer.
interface apb_slave_regfile_if #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
);
    logic                   pselx;
    logic                   penable;
    logic                   pwrite;
    logic [ADDRWIDTH-1:0]   paddr;
    logic [DATAWIDTH-1:0]   pwdata;
    logic [DATAWIDTH/8-1:0] pstrb;
    logic [2:0]             pprot;
    logic                   pready;
    logic                   pslverr;
    logic [DATAWIDTH-1:0]   prdata;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_slv_decode.sv
// Combinational register index and error decode for APB completers.
module apb_slv_decode
    import apb_slv_pkg::*;
#(
    parameter int ADDRWIDTH = 32,
    parameter int NREGS     = NREGS_DEFAULT,
    localparam int IW       = $clog2(NREGS)
) (
    input  logic [ADDRWIDTH-1:0] paddr_i,
    input  logic                 pwrite_i,
    input  logic [2:0]           pprot_i,
    output logic [IW-1:0]        idx_o,
    output logic                 err_o
);

    // Only the privilege bit matters for this decode.
    logic unused_prot;
    assign unused_prot = ^pprot_i[2:1];

    assign idx_o = paddr_i[IW+1:2];
    assign err_o = addr_err(64'(paddr_i), pwrite_i, pprot_i[0], NREGS);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer with a small word-addressed register file and ID word.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int          DATAWIDTH   = 32,
    parameter int          ADDRWIDTH   = 32,
    parameter int          NREGS       = NREGS_DEFAULT,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_slave_regfile_if.slave  apb
);

    localparam int IW    = $clog2(NREGS);
    localparam int NLANE = DATAWIDTH / 8;

    logic [IW-1:0]        idx;
    logic                 err;
    logic                 pready;
    logic                 wr_en;
    logic [DATAWIDTH-1:0] rd_word;
    logic [DATAWIDTH-1:0] regs_q [1:NREGS-1];

    apb_slv_decode #(
        .ADDRWIDTH (ADDRWIDTH),
        .NREGS     (NREGS)
    ) u_decode (
        .paddr_i  (apb.paddr),
        .pwrite_i (apb.pwrite),
        .pprot_i  (apb.pprot),
        .idx_o    (idx),
        .err_o    (err)
    );

`ifdef APB_SLV_WAIT_EN
    // state  | meaning
    // IDLE   | no transfer, waiting for a setup phase
    // WAIT   | access phase, counting down wait states
    // ACCESS | pready high for this single cycle
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        pready_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
        end else begin
            pready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (apb.pselx && !apb.penable) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q  <= ACCESS;
                            pready_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (!apb.pselx) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        // Hold at 1 until the requester shows penable.
                        if (apb.penable) begin
                            state_q  <= ACCESS;
                            cnt_q    <= '0;
                            pready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACCESS:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pready = pready_q;
`else
    localparam int wait_unused = WAIT_CYCLES;

    // Gated by reset so every output reads 0 while presetn is low.
    assign pready = apb.pselx & apb.penable & presetn;
`endif

    assign wr_en = apb.pselx & apb.penable & pready & apb.pwrite & ~err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (idx != '0)) begin
            for (int k = 0; k < NLANE; k++) begin
                if (apb.pstrb[k]) begin
                    regs_q[idx][8*k +: 8] <= apb.pwdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = DATAWIDTH'(ID_VALUE);
        if (idx != '0) begin
            rd_word = regs_q[idx];
        end
    end

    assign apb.pready  = pready;
    assign apb.pslverr = pready & err;
    assign apb.prdata  = (pready && !apb.pwrite && !err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed vector table,
// reset/abort sequences and randomized transfers against a word-array model.
module tb_apb_slave_regfile;

    localparam int          NREGS = 8;
    localparam logic [31:0] ID    = 32'hA5B0_0001;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic pclk;
    logic presetn;

    apb_slave_regfile_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

    apb_slave_regfile #(
        .DATAWIDTH   (32),
        .ADDRWIDTH   (32),
        .NREGS       (NREGS),
        .ID_VALUE    (ID),
        .WAIT_CYCLES (2)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [NREGS];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void predict(input logic wr, input logic [31:0] addr,
                                    input logic [2:0] prot,
                                    output logic [31:0] rd, output logic e);
        e = (addr % 4 != 0) || (addr >= NREGS * 4)
            || (wr && addr / 4 == 0)
            || (wr && !prot[0] && addr / 4 == NREGS - 1);
        rd = 32'h0;
        if (!e && !wr) rd = (addr / 4 == 0) ? ID : mem[addr[4:2]];
    endfunction

    task automatic model_commit(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot);
        logic [31:0] rd;
        logic        e;
        predict(wr, addr, prot, rd, e);
        if (wr && !e)
            for (int k = 0; k < 4; k++)
                if (strb[k]) mem[addr[4:2]][8*k +: 8] = wdata[8*k +: 8];
    endtask

    // Entered just after a rising edge; leaves just after the edge that completes.
    task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] exp_rd, input logic exp_err);
        int   nwait;
        bit   ok;
        logic [31:0] rd;
        logic        e;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        bus.pstrb   = strb;
        bus.pprot   = prot;
        @(negedge pclk);
        check({name, "_setup_pready"}, 32'(bus.pready), 32'h0);
        @(posedge pclk);
        #1 bus.penable = 1'b1;
        nwait = 0;
        ok    = 1'b0;
        rd    = '0;
        e     = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge pclk);
            if (bus.pready === 1'b1) begin
                ok = 1'b1;
                rd = bus.prdata;
                e  = bus.pslverr;
            end else begin
                nwait++;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=no_pready required=pready", name);
        end else begin
            check({name, "_rdata"}, rd, exp_rd);
            check({name, "_err"}, 32'(e), 32'(exp_err));
            check({name, "_wait"}, 32'(nwait), 32'(EXP_WAIT));
        end
        @(posedge pclk);
        #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        model_commit(wr, addr, wdata, strb, prot);
    endtask

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        bus.pstrb   = '0;
        bus.pprot   = '0;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;

        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b1;
        @(negedge pclk);
        check("rst_pready", 32'(bus.pready), 32'h0);
        check("rst_pslverr", 32'(bus.pslverr), 32'h0);
        check("rst_prdata", bus.prdata, 32'h0);
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        presetn     = 1'b1;
        @(posedge pclk);
        #1;

        bus.penable = 1'b1;
        @(negedge pclk);
        check("penable_only_pready", 32'(bus.pready), 32'h0);
        @(posedge pclk);
        #1 bus.penable = 1'b0;

        tbl[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 3'b000, 32'hA5B0_0001, 1'b0};
        tbl[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 32'h0,         1'b0};
        tbl[2]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'h5, 3'b000, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, 32'h08, 32'h0,        4'h0, 3'b000, 32'h00AD_00EF, 1'b0};
        tbl[4]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,         1'b1};
        tbl[5]  = '{1'b0, 32'h00, 32'h0,        4'h0, 3'b000, 32'hA5B0_0001, 1'b0};
        tbl[6]  = '{1'b0, 32'h20, 32'h0,        4'h0, 3'b000, 32'h0,         1'b1};
        tbl[7]  = '{1'b0, 32'h06, 32'h0,        4'h0, 3'b000, 32'h0,         1'b1};
        tbl[8]  = '{1'b1, 32'h1C, 32'h12345678, 4'hF, 3'b000, 32'h0,         1'b1};
        tbl[9]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 3'b000, 32'h0,         1'b0};
        tbl[10] = '{1'b1, 32'h1C, 32'h12345678, 4'hF, 3'b001, 32'h0,         1'b0};
        tbl[11] = '{1'b0, 32'h1C, 32'h0,        4'hF, 3'b000, 32'h1234_5678, 1'b0};
        tbl[12] = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 3'b000, 32'h0,         1'b0};
        tbl[13] = '{1'b0, 32'h10, 32'h0,        4'h0, 3'b000, 32'h0,         1'b0};
        tbl[14] = '{1'b1, 32'h08, 32'h11223344, 4'hA, 3'b000, 32'h0,         1'b0};
        tbl[15] = '{1'b0, 32'h08, 32'h0,        4'h0, 3'b000, 32'h11AD_33EF, 1'b0};
        tbl[16] = '{1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,         1'b1};
        tbl[17] = '{1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,         1'b1};

        for (int i = 0; i < 18; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                 tbl[i].strb, tbl[i].prot, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Reset dropped during the access phase of a write to 0xC.
        @(posedge pclk);
        #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h0C;
        bus.pwdata  = 32'hCAFE_F00D;
        bus.pstrb   = 4'hF;
        bus.pprot   = 3'b001;
        @(posedge pclk);
        #1 bus.penable = 1'b1;
        #2 presetn = 1'b0;
        #1;
        check("midrst_pready", 32'(bus.pready), 32'h0);
        check("midrst_pslverr", 32'(bus.pslverr), 32'h0);
        @(posedge pclk);
        #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        xfer("midrst_rd0c", 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
        xfer("midrst_rd1c", 1'b0, 32'h1C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [3:0]  strb;
            logic [2:0]  prot;
            int          r;
            r = $urandom_range(0, 15);
            if (r < 12)      addr = 32'(r) * 4;
            else if (r < 14) addr = 32'(r) * 4 + $urandom_range(1, 3);
            else             addr = 32'h1000_0000 | ($urandom_range(0, 7) * 4);
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            strb  = 4'($urandom_range(0, 15));
            prot  = 3'($urandom_range(0, 7));
            predict(wr, addr, prot, rd, e);
            xfer($sformatf("rnd%0d", n), wr, addr, wdata, strb, prot, rd, e);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk);
                #1;
            end
        end

        for (int i = 1; i < NREGS; i++) begin
            predict(1'b0, 32'(i) * 4, 3'b000, rd, e);
            xfer($sformatf("final%0d", i), 1'b0, 32'(i) * 4, 32'h0, 4'h0, 3'b000, rd, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
